// File: rtl/nfa_stream_engine.sv
// nfa_stream_engine: runtime-programmable NFA over a valid/ready symbol stream.
// NUM_STE state-transition elements share a programmable edge matrix. Matches
// on report STEs are drained one per cycle, lowest index first, into a report
// FIFO. The input is held off while any report is still pending.
module nfa_stream_engine #(
    parameter int NUM_STE   = 16,
    parameter int SYMBOL_W  = 8,
    parameter int OFFSET_W  = 32,
    parameter int RPT_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_class_we,
    input  logic                        cfg_edge_we,
    input  logic                        cfg_attr_we,
    input  logic [$clog2(NUM_STE)-1:0]  cfg_ste,
    input  logic [$clog2(NUM_STE)-1:0]  cfg_src,
    input  logic [SYMBOL_W-1:0]         cfg_symbol,
    input  logic                        cfg_bit,
    input  logic [1:0]                  cfg_start,
    input  logic                        cfg_report,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYMBOL_W-1:0]         in_symbol,
    input  logic                        in_last,
    output logic                        rpt_valid,
    input  logic                        rpt_ready,
    output logic [$clog2(NUM_STE)-1:0]  rpt_ste,
    output logic [OFFSET_W-1:0]         rpt_offset,
    output logic                        busy
);
    localparam int IDX_W = $clog2(NUM_STE);
    localparam int NSYM  = 2 ** SYMBOL_W;
    localparam int PTR_W = $clog2(RPT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = IDX_W + OFFSET_W;

    // Programmable tables
    logic [NSYM-1:0]    class_q [NUM_STE];
    logic [NSYM-1:0]    class_d [NUM_STE];
    logic [NUM_STE-1:0] edge_q  [NUM_STE];   // edge_q[src][dst]
    logic [NUM_STE-1:0] edge_d  [NUM_STE];
    logic [1:0]         start_q [NUM_STE];
    logic [1:0]         start_d [NUM_STE];
    logic [NUM_STE-1:0] report_q, report_d;

    // Stream state
    logic [NUM_STE-1:0]  act_q, act_d;
    logic [NUM_STE-1:0]  pend_q, pend_d;
    logic [OFFSET_W-1:0] pend_off_q, pend_off_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic                sod_q, sod_d;

    // Report FIFO
    logic [REC_W-1:0] mem_q [RPT_DEPTH];
    logic [REC_W-1:0] mem_d [RPT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational helpers
    logic [NUM_STE-1:0] edge_in_s;
    logic [NUM_STE-1:0] next_act_s;
    logic [IDX_W-1:0]   low_idx_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               fifo_full_s;
    logic               drain_s;
    logic               pop_s;

    assign in_ready_s  = (pend_q == '0);
    assign accept_s    = in_valid & in_ready_s;
    assign fifo_full_s = (cnt_q == CNT_W'(RPT_DEPTH));
    assign drain_s     = (pend_q != '0) & ~fifo_full_s;
    assign pop_s       = (cnt_q != '0) & rpt_ready;

    assign in_ready              = in_ready_s;
    assign rpt_valid             = (cnt_q != '0);
    assign {rpt_ste, rpt_offset} = mem_q[rd_ptr_q];
    assign busy                  = (pend_q != '0) | (cnt_q != '0);

    // Apply configuration writes; different kinds may land in the same cycle
    always_comb begin
        class_d  = class_q;
        edge_d   = edge_q;
        start_d  = start_q;
        report_d = report_q;
        if (cfg_class_we) begin
            class_d[cfg_ste][cfg_symbol] = cfg_bit;
        end else begin
            class_d = class_q;
        end
        if (cfg_edge_we) begin
            edge_d[cfg_src][cfg_ste] = cfg_bit;
        end else begin
            edge_d = edge_q;
        end
        if (cfg_attr_we) begin
            start_d[cfg_ste]  = cfg_start;
            report_d[cfg_ste] = cfg_report;
        end else begin
            start_d  = start_q;
            report_d = report_q;
        end
    end

    // Next activation vector for the presented symbol (start type 3 never arms)
    always_comb begin
        edge_in_s  = '0;
        next_act_s = '0;
        for (int j = 0; j < NUM_STE; j++) begin
            for (int i = 0; i < NUM_STE; i++) begin
                edge_in_s[j] = edge_in_s[j] | (act_q[i] & edge_q[i][j]);
            end
            next_act_s[j] = class_q[j][in_symbol] &
                            (edge_in_s[j] |
                             ((start_q[j] == 2'd1) & sod_q) |
                             (start_q[j] == 2'd2));
        end
    end

    // Lowest set index of the pending report vector
    always_comb begin
        low_idx_s = '0;
        for (int i = NUM_STE - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx_s = IDX_W'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Symbol acceptance and report drain; they never coincide since accept needs pend==0
    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_off_d = pend_off_q;
        off_d      = off_q;
        sod_d      = sod_q;
        if (accept_s) begin
            pend_d     = next_act_s & report_q;
            pend_off_d = off_q;
            if (in_last) begin
                act_d = '0;
                off_d = '0;
                sod_d = 1'b1;
            end else begin
                act_d = next_act_s;
                off_d = off_q + OFFSET_W'(1'b1);
                sod_d = 1'b0;
            end
        end else if (drain_s) begin
            pend_d = pend_q & (pend_q - NUM_STE'(1'b1));
        end else begin
            pend_d = pend_q;
        end
    end

    // Report FIFO pointer, occupancy and storage update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (drain_s) begin
            mem_d[wr_ptr_q] = {low_idx_s, pend_off_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({drain_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Register configuration tables
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STE; i++) begin
                class_q[i] <= '0;
                edge_q[i]  <= '0;
                start_q[i] <= 2'd0;
            end
            report_q <= '0;
        end else begin
            class_q  <= class_d;
            edge_q   <= edge_d;
            start_q  <= start_d;
            report_q <= report_d;
        end
    end

    // Register stream state; reset arms start-of-data
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q      <= '0;
            pend_q     <= '0;
            pend_off_q <= '0;
            off_q      <= '0;
            sod_q      <= 1'b1;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_off_q <= pend_off_d;
            off_q      <= off_d;
            sod_q      <= sod_d;
        end
    end

    // Register report FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RPT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_nfa_stream_engine.sv
// Directed testbench for nfa_stream_engine with hand-computed expectations.
module tb_nfa_stream_engine;
    localparam int NUM_STE   = 16;
    localparam int SYMBOL_W  = 8;
    localparam int OFFSET_W  = 32;
    localparam int RPT_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_class_we = 1'b0, cfg_edge_we = 1'b0, cfg_attr_we = 1'b0;
    logic [3:0]  cfg_ste = 4'd0, cfg_src = 4'd0;
    logic [7:0]  cfg_symbol = 8'd0;
    logic        cfg_bit = 1'b0;
    logic [1:0]  cfg_start = 2'd0;
    logic        cfg_report = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_symbol = 8'd0;
    logic        in_last = 1'b0;
    logic        rpt_valid;
    logic        rpt_ready = 1'b1;
    logic [3:0]  rpt_ste;
    logic [31:0] rpt_offset;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0]  q_ste[$];
    logic [31:0] q_off[$];

    nfa_stream_engine #(
        .NUM_STE(NUM_STE), .SYMBOL_W(SYMBOL_W),
        .OFFSET_W(OFFSET_W), .RPT_DEPTH(RPT_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_class_we(cfg_class_we), .cfg_edge_we(cfg_edge_we), .cfg_attr_we(cfg_attr_we),
        .cfg_ste(cfg_ste), .cfg_src(cfg_src), .cfg_symbol(cfg_symbol), .cfg_bit(cfg_bit),
        .cfg_start(cfg_start), .cfg_report(cfg_report),
        .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol), .in_last(in_last),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_ste(rpt_ste),
        .rpt_offset(rpt_offset), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every report handshake; inputs are stable from negedge to the next posedge
    always @(negedge clk) begin
        if (rpt_valid && rpt_ready) begin
            q_ste.push_back(rpt_ste);
            q_off.push_back(rpt_offset);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_class(input logic [3:0] ste, input logic [7:0] sym, input logic b);
        cfg_class_we = 1'b1; cfg_ste = ste; cfg_symbol = sym; cfg_bit = b;
        cycles(1);
        cfg_class_we = 1'b0;
    endtask

    task automatic cfg_edge(input logic [3:0] src, input logic [3:0] dst, input logic b);
        cfg_edge_we = 1'b1; cfg_src = src; cfg_ste = dst; cfg_bit = b;
        cycles(1);
        cfg_edge_we = 1'b0;
    endtask

    task automatic cfg_attr(input logic [3:0] ste, input logic [1:0] st, input logic rep);
        cfg_attr_we = 1'b1; cfg_ste = ste; cfg_start = st; cfg_report = rep;
        cycles(1);
        cfg_attr_we = 1'b0;
    endtask

    // Present one symbol and return #1 after the edge where it is accepted
    task automatic send(input logic [7:0] sym, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_symbol = sym; in_last = last;
        while (in_ready !== 1'b1 && n < 200) begin
            cycles(1);
            n++;
        end
        if (n >= 200) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: symbol %0h not accepted within %0d cycles", sym, n);
        end
        cycles(1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests_run++; if (rpt_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rpt_valid: got %b want 0", rpt_valid); end
        tests_run++; if (rpt_ste !== 4'd0) begin tests_failed++; $display("FAIL reset_rpt_ste: got %0d want 0", rpt_ste); end
        tests_run++; if (rpt_offset !== 32'd0) begin tests_failed++; $display("FAIL reset_rpt_offset: got %0d want 0", rpt_offset); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_symbol = 8'h00;
        for (int i = 0; i < 3; i++) begin
            in_last = (i == 2);
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            cycles(1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        cycles(2);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        cfg_class(4'd0, 8'h61, 1'b1);
        cfg_attr(4'd0, 2'd1, 1'b0);
        cfg_class(4'd1, 8'h62, 1'b1);
        cfg_attr(4'd1, 2'd0, 1'b1);
        cfg_edge(4'd0, 4'd1, 1'b1);
        q_ste.delete(); q_off.delete();
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        cycles(6);
        tests_run++;
        if (q_ste.size() != 1) begin
            tests_failed++; $display("FAIL basic_count: got %0d want 1", q_ste.size());
        end else if (q_ste[0] !== 4'd1 || q_off[0] !== 32'd1) begin
            tests_failed++; $display("FAIL basic_record: got ste=%0d off=%0d want ste=1 off=1", q_ste[0], q_off[0]);
        end
        q_ste.delete(); q_off.delete();
        send(8'h62, 1'b0);
        send(8'h61, 1'b1);
        cycles(6);
        tests_run++; if (q_ste.size() != 0) begin tests_failed++; $display("FAIL basic_no_report: got %0d reports want 0", q_ste.size()); end
    endtask

    task automatic test_all_input();
        logic [31:0] exp_off [2];
        exp_off[0] = 32'd2; exp_off[1] = 32'd4;
        cfg_attr(4'd0, 2'd2, 1'b0);
        q_ste.delete(); q_off.delete();
        send(8'h00, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        cycles(6);
        tests_run++; if (q_ste.size() != 2) begin tests_failed++; $display("FAIL all_input_count: got %0d want 2", q_ste.size()); end
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (k >= q_ste.size()) begin
                tests_failed++; $display("FAIL all_input_rec[%0d]: missing, want ste=1 off=%0d", k, exp_off[k]);
            end else if (q_ste[k] !== 4'd1 || q_off[k] !== exp_off[k]) begin
                tests_failed++; $display("FAIL all_input_rec[%0d]: got ste=%0d off=%0d want ste=1 off=%0d", k, q_ste[k], q_off[k], exp_off[k]);
            end
        end
    endtask

    task automatic test_multi_report();
        logic [3:0] exp_ste [3];
        int stall;
        exp_ste[0] = 4'd2; exp_ste[1] = 4'd5; exp_ste[2] = 4'd7;
        for (int k = 0; k < 3; k++) begin
            cfg_class(exp_ste[k], 8'h41, 1'b1);
            cfg_attr(exp_ste[k], 2'd1, 1'b1);
        end
        q_ste.delete(); q_off.delete();
        send(8'h41, 1'b1);
        tests_run++; if (rpt_valid !== 1'b0) begin tests_failed++; $display("FAIL multi_first_valid: got %b want 0 one cycle after accept", rpt_valid); end
        stall = 0;
        while (in_ready !== 1'b1 && stall < 50) begin
            stall++;
            cycles(1);
        end
        tests_run++; if (stall != 3) begin tests_failed++; $display("FAIL multi_stall: got %0d cycles want 3", stall); end
        cycles(6);
        tests_run++; if (q_ste.size() != 3) begin tests_failed++; $display("FAIL multi_count: got %0d want 3", q_ste.size()); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (k >= q_ste.size()) begin
                tests_failed++; $display("FAIL multi_rec[%0d]: missing, want ste=%0d off=0", k, exp_ste[k]);
            end else if (q_ste[k] !== exp_ste[k] || q_off[k] !== 32'd0) begin
                tests_failed++; $display("FAIL multi_rec[%0d]: got ste=%0d off=%0d want ste=%0d off=0", k, q_ste[k], q_off[k], exp_ste[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        cfg_class(4'd3, 8'h5A, 1'b1);
        cfg_attr(4'd3, 2'd2, 1'b1);
        q_ste.delete(); q_off.delete();
        rpt_ready = 1'b0;
        for (int k = 0; k < RPT_DEPTH + 1; k++) begin
            send(8'h5A, 1'b0);
        end
        cycles(5);
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_busy: got %b want 1", busy); end
        tests_run++; if (rpt_valid !== 1'b1 || rpt_ste !== 4'd3 || rpt_offset !== 32'd0) begin
            tests_failed++; $display("FAIL bp_head: got v=%b ste=%0d off=%0d want v=1 ste=3 off=0", rpt_valid, rpt_ste, rpt_offset);
        end
        rpt_ready = 1'b1;
        cycles(20);
        tests_run++; if (q_ste.size() != RPT_DEPTH + 1) begin tests_failed++; $display("FAIL bp_count: got %0d want %0d", q_ste.size(), RPT_DEPTH + 1); end
        for (int k = 0; k < RPT_DEPTH + 1; k++) begin
            tests_run++;
            if (k >= q_ste.size()) begin
                tests_failed++; $display("FAIL bp_rec[%0d]: missing, want ste=3 off=%0d", k, k);
            end else if (q_ste[k] !== 4'd3 || q_off[k] !== 32'(k)) begin
                tests_failed++; $display("FAIL bp_rec[%0d]: got ste=%0d off=%0d want ste=3 off=%0d", k, q_ste[k], q_off[k], k);
            end
        end
        send(8'h00, 1'b1);
        cycles(2);
    endtask

    task automatic test_last_restart();
        cfg_attr(4'd0, 2'd1, 1'b0);
        cfg_class(4'd4, 8'h61, 1'b1);
        cfg_attr(4'd4, 2'd2, 1'b0);
        cfg_edge(4'd4, 4'd1, 1'b1);
        q_ste.delete(); q_off.delete();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h61, 1'b1);
        cycles(4);
        tests_run++; if (q_ste.size() != 0) begin tests_failed++; $display("FAIL restart_s1: got %0d reports want 0", q_ste.size()); end
        q_ste.delete(); q_off.delete();
        send(8'h62, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        cycles(6);
        tests_run++;
        if (q_ste.size() != 1) begin
            tests_failed++; $display("FAIL restart_s2_count: got %0d want 1", q_ste.size());
        end else if (q_ste[0] !== 4'd1 || q_off[0] !== 32'd2) begin
            tests_failed++; $display("FAIL restart_s2_rec: got ste=%0d off=%0d want ste=1 off=2", q_ste[0], q_off[0]);
        end
        cfg_attr(4'd4, 2'd0, 1'b0);
        q_ste.delete(); q_off.delete();
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        cycles(6);
        tests_run++;
        if (q_ste.size() != 1) begin
            tests_failed++; $display("FAIL restart_sod_count: got %0d want 1", q_ste.size());
        end else if (q_ste[0] !== 4'd1 || q_off[0] !== 32'd1) begin
            tests_failed++; $display("FAIL restart_sod_rec: got ste=%0d off=%0d want ste=1 off=1", q_ste[0], q_off[0]);
        end
    endtask

    task automatic test_reset_busy();
        rpt_ready = 1'b0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        cycles(3);
        tests_run++; if (busy !== 1'b1 || rpt_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rb_pre: got busy=%b valid=%b want 1 1", busy, rpt_valid);
        end
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        tests_run++; if (rpt_valid !== 1'b0) begin tests_failed++; $display("FAIL rb_rpt_valid: got %b want 0", rpt_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rb_busy: got %b want 0", busy); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rb_in_ready: got %b want 1", in_ready); end
        rpt_ready = 1'b1;
        q_ste.delete(); q_off.delete();
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        cycles(6);
        tests_run++; if (q_ste.size() != 0) begin tests_failed++; $display("FAIL rb_cleared_cfg: got %0d reports want 0", q_ste.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_basic();
        test_all_input();
        test_multi_report();
        test_backpressure();
        test_last_restart();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
